// File: rtl/sm_hex_display_scan.sv
// sm_hex_display_scan: shadowed hex display driver.
// Latches a debug value on an update strobe and shows it as static per-digit
// segment buses and as a time-multiplexed scan (one segment bus plus digit
// selects). Supports leading-zero blanking and configurable output polarity.
module sm_hex_display_scan #(
    parameter int DIGITS         = 8,     // 1..8 hex digits
    parameter int SCAN_DIV       = 16,    // refresh prescaler width
    parameter bit SEG_ACTIVE_LOW = 1'b1,  // 1: lit segment drives 0
    parameter bit DIG_ACTIVE_LOW = 1'b1   // 1: selected digit drives 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           value,
    input  logic                  update,
    input  logic                  blank_lz,
    output logic [DIGITS*7-1:0]   seg_all,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int                IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    // Hex nibble to active-high segments, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    logic [4*DIGITS-1:0] shadow_q;
    logic [SCAN_DIV-1:0] presc_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS*7-1:0] seg_all_q, glyph_all_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                frame_done_q, frame_done_d;
    logic                wrap;

    // Decode every digit of the shadow, blanking leading zeros above digit 0.
    always_comb begin
        logic any_nz;
        // NOTE: every variable gets a default before the loop so no latch is inferred;
        // combinational blocks use blocking assignments so any_nz accumulates in order.
        any_nz      = 1'b0;
        glyph_all_d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz = any_nz | (|shadow_q[4*i +: 4]);
            if (blank_lz && !any_nz && i != 0)
                glyph_all_d[7*i +: 7] = SEG_OFF;
            else
                glyph_all_d[7*i +: 7] = hex_to_seg(shadow_q[4*i +: 4]) ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    // Next scan index, scan segment/select pair and frame marker.
    always_comb begin
        wrap = &presc_q;
        idx_d = idx_q;
        if (wrap)
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        seg_d = glyph_all_d[7*int'(idx_d) +: 7];
        dig_sel_d = '0;
        dig_sel_d[idx_d] = 1'b1;
        dig_sel_d = dig_sel_d ^ {DIGITS{DIG_ACTIVE_LOW}};
        frame_done_d = wrap && (idx_q == IDX_W'(DIGITS - 1));
    end

    // Shadow, prescaler, scan index and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and outranks update; all state uses non-blocking
        // assignments so every register samples pre-edge values.
        if (rst) begin
            shadow_q     <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            seg_all_q    <= {DIGITS{SEG_OFF}};
            seg_q        <= SEG_OFF;
            dig_sel_q    <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            if (update)
                shadow_q <= value[4*DIGITS-1:0];
            presc_q      <= presc_q + 1'b1;
            idx_q        <= idx_d;
            seg_all_q    <= glyph_all_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_all    = seg_all_q;
    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Bench for sm_hex_display_scan: three configurations share one stimulus
// stream; a cycle-count based model predicts every output each cycle.
module tb_sm_hex_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic        update = 1'b0;
    logic        blank_lz = 1'b0;

    always #5 clk = ~clk;

    logic [55:0] sa_a;  logic [6:0] sg_a; logic [7:0] dg_a; logic fd_a;
    logic [27:0] sa_b;  logic [6:0] sg_b; logic [3:0] dg_b; logic fd_b;
    logic [6:0]  sa_c;  logic [6:0] sg_c; logic [0:0] dg_c; logic fd_c;

    sm_hex_display_scan #(.DIGITS(8), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .value(value), .update(update), .blank_lz(blank_lz),
        .seg_all(sa_a), .seg(sg_a), .dig_sel(dg_a), .frame_done(fd_a));
    sm_hex_display_scan #(.DIGITS(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .value(value), .update(update), .blank_lz(blank_lz),
        .seg_all(sa_b), .seg(sg_b), .dig_sel(dg_b), .frame_done(fd_b));
    sm_hex_display_scan #(.DIGITS(1), .SCAN_DIV(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_c (
        .clk(clk), .rst(rst), .value(value), .update(update), .blank_lz(blank_lz),
        .seg_all(sa_c), .seg(sg_c), .dig_sel(dg_c), .frame_done(fd_c));

    // Per-configuration parameters (index 0..2 = dut_a..dut_c).
    localparam int CD  [3] = '{8, 4, 1};
    localparam int CSD [3] = '{3, 2, 2};
    localparam bit CSL [3] = '{1'b1, 1'b1, 1'b0};
    localparam bit CDL [3] = '{1'b1, 1'b1, 1'b0};
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Glyph digit i of configuration c should show for shadow value sh.
    function automatic logic [6:0] glyph(input int c, input logic [31:0] sh, input int i, input logic bl);
        logic [31:0] vis;
        logic [6:0]  g;
        vis = (CD[c] == 8) ? sh : (sh & ((32'd1 << (4 * CD[c])) - 32'd1));
        if (bl && i > 0 && (vis >> (4 * i)) == 32'd0) g = 7'h00;
        else g = HEX[int'((vis >> (4 * i)) & 32'hF)];
        if (CSL[c]) g = ~g;
        return g;
    endfunction

    // Model: n edges after reset the prescaler holds n mod 2^SD and the index is
    // floor(n / 2^SD) mod DIGITS; outputs after an edge reflect pre-edge shadow.
    bit          valid = 1'b0;
    int          n_m [3];
    logic [31:0] sh_m [3];
    logic [55:0] exp_sa [3];
    logic [6:0]  exp_sg [3];
    logic [7:0]  exp_dg [3];
    logic        exp_fd [3];
    int          idx;

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                valid = 1'b1;
                n_m[c] = 0;
                sh_m[c] = '0;
                exp_sa[c] = '0;
                exp_dg[c] = '0;
                for (int i = 0; i < CD[c]; i++) begin
                    exp_sa[c][7*i +: 7] = CSL[c] ? 7'h7F : 7'h00;
                    exp_dg[c][i] = CDL[c];
                end
                exp_sg[c] = CSL[c] ? 7'h7F : 7'h00;
                exp_fd[c] = 1'b0;
            end else if (valid) begin
                n_m[c]++;
                idx = (n_m[c] >> CSD[c]) % CD[c];
                exp_sa[c] = '0;
                exp_dg[c] = '0;
                for (int i = 0; i < CD[c]; i++) begin
                    exp_sa[c][7*i +: 7] = glyph(c, sh_m[c], i, blank_lz);
                    exp_dg[c][i] = (i == idx) ^ CDL[c];
                end
                exp_sg[c] = glyph(c, sh_m[c], idx, blank_lz);
                exp_fd[c] = (n_m[c] % (1 << CSD[c]) == 0) && ((n_m[c] >> CSD[c]) % CD[c] == 0);
                if (update) sh_m[c] = value;
            end
        end
    end

    logic [55:0] act_sa [3];
    logic [6:0]  act_sg [3];
    logic [7:0]  act_dg [3];
    logic        act_fd [3];
    assign act_sa[0] = sa_a;            assign act_sa[1] = {28'd0, sa_b}; assign act_sa[2] = {49'd0, sa_c};
    assign act_sg[0] = sg_a;            assign act_sg[1] = sg_b;          assign act_sg[2] = sg_c;
    assign act_dg[0] = dg_a;            assign act_dg[1] = {4'd0, dg_b};  assign act_dg[2] = {7'd0, dg_c};
    assign act_fd[0] = fd_a;            assign act_fd[1] = fd_b;          assign act_fd[2] = fd_c;

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (valid) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("model seg_all cfg%0d", c), act_sa[c], exp_sa[c]);
                check($sformatf("model seg cfg%0d", c), act_sg[c], exp_sg[c]);
                check($sformatf("model dig_sel cfg%0d", c), act_dg[c], exp_dg[c]);
                check($sformatf("model frame_done cfg%0d", c), act_fd[c], exp_fd[c]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        value = v;
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
    endtask

    int pulses;
    int k;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Shadow 0 without blanking: every digit shows "0".
        check("pre-update digits", sa_a, {8{7'h40}});

        // Test 1: full hex word, two edges after the update.
        load(32'h1234_5678);
        check("12345678 seg_all", sa_a, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
        check("12345678 digit0 active-high", sa_c, 7'h7F);

        // Test 2: leading-zero blanking.
        blank_lz = 1'b1;
        load(32'h0000_00A0);
        check("A0 blanked", sa_a, {{6{7'h7F}}, 7'h08, 7'h40});
        load(32'h0);
        check("zero blanked", sa_a, {{7{7'h7F}}, 7'h40});
        blank_lz = 1'b0;
        tick();
        check("zero unblanked", sa_a, {8{7'h40}});

        // Test 3: scan pairs and frame period on the 4-digit build.
        load(32'h0000_BEEF);
        k = 0;
        while (fd_b !== 1'b1 && k < 64) begin tick(); k++; end
        check("frame_done seen", fd_b, 1'b1);
        check("scan d0 sel", dg_b, 4'hE);  check("scan d0 seg", sg_b, 7'h0E);
        repeat (4) tick();
        check("scan d1 sel", dg_b, 4'hD);  check("scan d1 seg", sg_b, 7'h06);
        repeat (4) tick();
        check("scan d2 sel", dg_b, 4'hB);  check("scan d2 seg", sg_b, 7'h06);
        repeat (4) tick();
        check("scan d3 sel", dg_b, 4'h7);  check("scan d3 seg", sg_b, 7'h03);
        pulses = 0;
        repeat (4) begin tick(); pulses += int'(fd_b); end
        check("frame period 16", pulses, 1);
        check("frame wrap sel", dg_b, 4'hE);

        // Test 4: reset while index 2 is displayed.
        k = 0;
        while (dg_b !== 4'hB && k < 64) begin tick(); k++; end
        check("reached index 2", dg_b, 4'hB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset seg_all off", sa_b, {4{7'h7F}});
        check("reset seg off", sg_b, 7'h7F);
        check("reset dig_sel off", dg_b, 4'hF);
        check("reset frame_done", fd_b, 1'b0);
        tick();
        check("restart sel", dg_b, 4'hE);
        check("restart seg", sg_b, 7'h40);

        // Test 5: update coincides with the prescaler wrap into index 1.
        tick();
        tick();
        value = 32'h0000_1234;
        update = 1'b1;
        tick();
        update = 1'b0;
        check("wrap+update old nibble sel", dg_b, 4'hD);
        check("wrap+update old nibble seg", sg_b, 7'h40);
        tick();
        check("new nibble seg", sg_b, 7'h30);
        check("new seg_all", sa_b, {7'h79, 7'h24, 7'h30, 7'h19});

        // Test 6: single digit, active-high polarities.
        load(32'h0000_0009);
        check("1-digit seg_all", sa_c, 7'h6F);
        check("1-digit seg", sg_c, 7'h6F);
        check("1-digit dig_sel", dg_c, 1'b1);
        pulses = 0;
        repeat (16) begin tick(); pulses += int'(fd_c); end
        check("1-digit frame pulses", pulses, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
